i2c_multi_channel_sequencer: RTL
================================

// Module: i2c_multi_channel_sequencer
// PURPOSE
//  Parametrised successor to the single-slave I2C master controller. It owns a
//  table of NUM_CH transaction channels (slave addr, register pointer, byte
//  count, direction). It services enabled channels round-robin through one
//  I2C_Master instance. Write bytes are sourced from, and read bytes stored to,
//  a shared byte RAM partitioned MAX_BYTES per channel. Adds NACK abort,
//  per-channel error flags, transaction timeout and a continuous-poll mode.
// PARAMETERS
//  NUM_CH       4      number of channels (1..16)
//  MAX_BYTES    8      bytes per channel RAM window (power of 2, <=63)
//  CH_W         2      clog2(NUM_CH), min 1
//  BY_W         3      clog2(MAX_BYTES)
//  TIMEOUT_CYC  50000  clk cycles allowed between master_done pulses
// PORTS
//  clk            in   1            system clock
//  reset          in   1            asynchronous, active-high reset
//  cfg_w          in   1            write channel table entry
//  cfg_ch         in   CH_W         channel index for cfg_w
//  cfg_data       in   24           {en,rw,nbytes[5:0],dev_add[6:0],rsvd,ptr[7:0]}
//  start          in   1            1-cycle pulse: run one pass over enabled channels
//  poll_mode      in   1            1: restart the pass automatically after it ends
//  busy           out  1            pass in progress
//  pass_done      out  1            1-cycle pulse at end of each pass
//  err_flags      out  NUM_CH       sticky NACK/timeout flag per channel
//  err_clr        in   1            clears err_flags
//  ram_add        out  CH_W+BY_W    {ch,byte_idx}
//  ram_din        out  8            read data to RAM
//  ram_w          out  1            RAM write strobe
//  ram_dout       in   8            RAM read data, 1-cycle synchronous latency
//  master_go      out  1            1-cycle start pulse
//  master_rw      out  1            1=read
//  master_nbyte   out  6            byte count
//  master_dev     out  7            slave address
//  master_ptr     out  8            slave register pointer
//  master_wdata   out  8            current write byte
//  master_stop    out  1            held high from last byte's done until master_ready
//  master_ready   in   1            master idle
//  master_done    in   1            1-cycle pulse per byte completed
//  master_ack     in   1            slave ACK, valid with master_done
//  master_rdata   in   8            read byte, valid with master_done
// BEHAVIOUR
//  - Reset: all outputs 0; table entries cleared (en=0); state IDLE; ch ptr=0.
//  - cfg_w is accepted in any state; a change to the active channel takes effect
//    on its next service. nbytes is clamped to MAX_BYTES; nbytes=0 is treated as
//    en=0.
//  - FSM:
//      IDLE -start-> SCAN
//      SCAN: find the next enabled ch from ch ptr, 1 ch/cycle.
//            None in a full sweep -> DONE.
//      SCAN -> FETCH (rw=0) or GO (rw=1)
//      FETCH: drive ram_add, wait 1 cycle, latch master_wdata -> GO
//      GO: wait master_ready, pulse master_go 1 cycle -> XFER
//      XFER, on master_done:
//        - ack=0: set err_flags[ch], assert master_stop -> STOPW
//        - read: ram_w=1, ram_din=master_rdata at {ch,idx}, same cycle
//        - idx==nbytes-1: master_stop=1 -> STOPW
//        - else idx++; for a write, refetch the next byte; master_wdata is
//          valid within 2 cycles of master_done
//      STOPW: wait master_ready, drop stop, advance ch -> SCAN
//      DONE: pass_done pulse; poll_mode ? SCAN : IDLE
//  - Timeout: counter resets on go and on each master_done. Reaching
//    TIMEOUT_CYC sets err_flags[ch], asserts stop -> STOPW.
//  - busy=1 in every state except IDLE.
//  - start while busy is ignored.
//  - err_clr and an error on the same cycle: the error wins.
//  - Clearing poll_mode mid-pass finishes the current pass, then IDLE.
//  - Async reset mid-transfer: outputs to 0 immediately, no stop is issued;
//    the master is reset by the same signal.
//  - ch ptr wraps NUM_CH-1 -> 0. Round-robin resumes after the last serviced
//    channel.
// STRUCTURE
//  - Package i2c_seq_pkg: FSM state encoding, cfg_data field offsets, and
//    RW_READ/RW_WRITE constants.
//  - Sub-module i2c_seq_chan_table: NUM_CH x 24 register file with an async
//    read port for the sequencer.
//  - Top level: FSM, byte/timeout counters, RAM/master muxing.
// TESTING
//  - ch0 {en,rw=0,n=3,dev=0x48,ptr=0x01}, RAM {A1,B2,C3}, start: one go;
//    wdata A1,B2,C3; stop on the 3rd done; pass_done.
//  - ch2 read n=2, dev=0x4F, model returns 5A,7E: ram_w at adds {2,0},{2,1}
//    with 5A,7E.
//  - ch1 NACK on byte 0 of 4: err_flags=0010, stop asserted, no further done
//    consumed, ch3 still serviced.
//  - No master_done after go, TIMEOUT_CYC=100: err flag set on cycle 100,
//    stop, pass completes.
//  - poll_mode=1, ch0 and ch3 enabled: order ch0,ch3,ch0,ch3.
//    Clear poll_mode: ends after the current pass.
//  - Reset asserted in XFER: all outputs 0 asynchronously, IDLE, table
//    cleared; start then gives pass_done with no master_go.

Source files
------------

// File: rtl/i2c_seq_pkg.sv
// Shared definitions for the multi-channel I2C sequencer: FSM states,
// channel-table field layout and transfer direction constants.
package i2c_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_FETCH,
    ST_GO,
    ST_XFER,
    ST_STOPW,
    ST_DONE
  } seq_state_t;

  // Channel entry layout: {en, rw, nbytes[5:0], dev_add[6:0], rsvd, ptr[7:0]}
  localparam int CFG_EN      = 23;
  localparam int CFG_RW      = 22;
  localparam int CFG_NB_LSB  = 16;
  localparam int CFG_DEV_LSB = 9;
  localparam int CFG_RSVD    = 8;
  localparam int CFG_PTR_LSB = 0;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  function automatic logic [5:0] clampBytes(input logic [5:0] n, input int maxBytes);
    return (n > 6'(maxBytes)) ? 6'(maxBytes) : n;
  endfunction

endpackage

// File: rtl/i2c_seq_chan_table.sv
// Channel configuration register file: one synchronous write port for the
// host, one asynchronous read port for the sequencer FSM.
module i2c_seq_chan_table #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_wr,
  input  logic [CH_W-1:0] i_wr_ch,
  input  logic [23:0]     i_wr_data,
  input  logic [CH_W-1:0] i_rd_ch,
  output logic [23:0]     o_rd_data
);

  logic [23:0] r_table [NUM_CH];

  // Out-of-range channel indices are dropped when NUM_CH is not a power of 2
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < NUM_CH; i++) r_table[i] <= '0;
    end else if (i_wr && (int'(i_wr_ch) < NUM_CH)) begin
      r_table[i_wr_ch] <= i_wr_data;
    end
  end

  assign o_rd_data = r_table[i_rd_ch];

endmodule

// File: rtl/i2c_multi_channel_sequencer.sv
// Round-robin sequencer driving one I2C master over a table of channels,
// moving write/read bytes through a shared byte RAM partitioned per channel.
module i2c_multi_channel_sequencer
  import i2c_seq_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int MAX_BYTES   = 8,
  parameter int CH_W        = 2,
  parameter int BY_W        = 3,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_cfg_w,
  input  logic [CH_W-1:0]      i_cfg_ch,
  input  logic [23:0]          i_cfg_data,
  input  logic                 i_start,
  input  logic                 i_poll_mode,
  output logic                 o_busy,
  output logic                 o_pass_done,
  output logic [NUM_CH-1:0]    o_err_flags,
  input  logic                 i_err_clr,
  output logic [CH_W+BY_W-1:0] o_ram_add,
  output logic [7:0]           o_ram_din,
  output logic                 o_ram_w,
  input  logic [7:0]           i_ram_dout,
  output logic                 o_master_go,
  output logic                 o_master_rw,
  output logic [5:0]           o_master_nbyte,
  output logic [6:0]           o_master_dev,
  output logic [7:0]           o_master_ptr,
  output logic [7:0]           o_master_wdata,
  output logic                 o_master_stop,
  input  logic                 i_master_ready,
  input  logic                 i_master_done,
  input  logic                 i_master_ack,
  input  logic [7:0]           i_master_rdata
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [CH_W:0]    SWEEP_LEN = (CH_W + 1)'(NUM_CH);
  localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(NUM_CH - 1);

  seq_state_t             r_state;
  logic [CH_W-1:0]        r_ch;
  logic [CH_W:0]          r_visited;
  logic [BY_W-1:0]        r_idx;
  logic [CH_W+BY_W-1:0]   r_ramAdd;
  logic                   r_fetchWait;
  logic [1:0]             r_refetch;
  logic [TMO_W-1:0]       r_tmo;

  logic [23:0]            w_entry;
  logic                   w_en;
  logic [5:0]             w_nbyte;
  logic [CH_W-1:0]        w_chNext;
  logic                   w_store;
  logic                   w_lastByte;
  logic                   w_unusedRsvd;

  i2c_seq_chan_table #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_table (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_wr      (i_cfg_w),
    .i_wr_ch   (i_cfg_ch),
    .i_wr_data (i_cfg_data),
    .i_rd_ch   (r_ch),
    .o_rd_data (w_entry)
  );

  assign w_en         = w_entry[CFG_EN] && (w_entry[CFG_NB_LSB +: 6] != 6'd0);
  assign w_nbyte      = clampBytes(w_entry[CFG_NB_LSB +: 6], MAX_BYTES);
  assign w_chNext     = (r_ch == CH_LAST) ? '0 : r_ch + 1'b1;
  assign w_lastByte   = (6'(r_idx) == o_master_nbyte - 6'd1);
  assign w_unusedRsvd = w_entry[CFG_RSVD];

  // Read bytes land in RAM in the very cycle the master reports them
  assign w_store   = (r_state == ST_XFER) && i_master_done && i_master_ack &&
                     (o_master_rw == RW_READ);
  assign o_ram_w   = w_store;
  assign o_ram_din = w_store ? i_master_rdata : 8'h00;
  assign o_ram_add = w_store ? {r_ch, r_idx} : r_ramAdd;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state        <= ST_IDLE;
      r_ch           <= '0;
      r_visited      <= '0;
      r_idx          <= '0;
      r_ramAdd       <= '0;
      r_fetchWait    <= 1'b0;
      r_refetch      <= 2'd0;
      r_tmo          <= '0;
      o_busy         <= 1'b0;
      o_pass_done    <= 1'b0;
      o_err_flags    <= '0;
      o_master_go    <= 1'b0;
      o_master_rw    <= 1'b0;
      o_master_nbyte <= 6'd0;
      o_master_dev   <= 7'd0;
      o_master_ptr   <= 8'd0;
      o_master_wdata <= 8'd0;
      o_master_stop  <= 1'b0;
    end else begin
      o_master_go <= 1'b0;
      o_pass_done <= 1'b0;
      // A flag set later in this block overrides the clear for that channel
      if (i_err_clr) o_err_flags <= '0;

      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            o_busy    <= 1'b1;
            r_visited <= '0;
            r_state   <= ST_SCAN;
          end
        end

        ST_SCAN: begin
          if (r_visited == SWEEP_LEN) begin
            r_state <= ST_DONE;
          end else begin
            r_visited <= r_visited + 1'b1;
            if (w_en) begin
              o_master_rw    <= w_entry[CFG_RW];
              o_master_nbyte <= w_nbyte;
              o_master_dev   <= w_entry[CFG_DEV_LSB +: 7];
              o_master_ptr   <= w_entry[CFG_PTR_LSB +: 8];
              r_idx          <= '0;
              r_ramAdd       <= {r_ch, {BY_W{1'b0}}};
              r_fetchWait    <= 1'b0;
              r_state        <= (w_entry[CFG_RW] == RW_READ) ? ST_GO : ST_FETCH;
            end else begin
              r_ch <= w_chNext;
            end
          end
        end

        ST_FETCH: begin
          r_fetchWait <= 1'b1;
          if (r_fetchWait) begin
            o_master_wdata <= i_ram_dout;
            r_state        <= ST_GO;
          end
        end

        ST_GO: begin
          if (i_master_ready) begin
            o_master_go <= 1'b1;
            r_tmo       <= '0;
            r_refetch   <= 2'd0;
            r_state     <= ST_XFER;
          end
        end

        // Refetch pipeline: address issued on done, RAM data two cycles later
        ST_XFER: begin
          if (r_refetch == 2'd2) begin
            r_refetch <= 2'd1;
          end else if (r_refetch == 2'd1) begin
            o_master_wdata <= i_ram_dout;
            r_refetch      <= 2'd0;
          end

          if (i_master_done) begin
            r_tmo <= '0;
            if (!i_master_ack || w_lastByte) begin
              if (!i_master_ack) o_err_flags[r_ch] <= 1'b1;
              o_master_stop <= 1'b1;
              r_state       <= ST_STOPW;
            end else begin
              r_idx <= r_idx + 1'b1;
              if (o_master_rw == RW_WRITE) begin
                r_ramAdd  <= {r_ch, r_idx + 1'b1};
                r_refetch <= 2'd2;
              end
            end
          end else if (r_tmo == TMO_LAST) begin
            o_err_flags[r_ch] <= 1'b1;
            o_master_stop     <= 1'b1;
            r_state           <= ST_STOPW;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end

        ST_STOPW: begin
          if (i_master_ready) begin
            o_master_stop <= 1'b0;
            r_ch          <= w_chNext;
            r_state       <= ST_SCAN;
          end
        end

        ST_DONE: begin
          o_pass_done <= 1'b1;
          r_visited   <= '0;
          if (i_poll_mode) begin
            r_state <= ST_SCAN;
          end else begin
            o_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
